ddr4_refresh_scheduler: RTL and testbench

//  Upstream refresh-request source for the DDR4 controller FSM; the controller enters its REFRESH state on this block's request.
//  - Counts tREFI intervals on clk_50mhz and tracks owed refreshes (postponement up to MAX_POSTPONE).
//  - Raises ref_req and ref_urgent, and holds off re-requesting for tRFC after each accepted refresh.

---
 rtl/ddr4_refresh_scheduler.sv | 132 +++++++++++++
 tb/tb_ddr4_refresh_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_refresh_scheduler.sv
// DDR4 refresh-request scheduler: counts tREFI intervals, tracks owed refreshes and
// holds off for tRFC after each accepted refresh. Optional macro REF_STATS_EN adds ref_count.
module ddr4_refresh_scheduler #(
  parameter int unsigned TREFI_CYC    = 390,
  parameter int unsigned TRFC_CYC     = 18,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic        clk_50mhz,
  input  logic        rst_50mhz,
  input  logic        init_done,
  input  logic        ref_ack,
  output logic        ref_req,
  output logic        ref_urgent,
  output logic        ref_busy,
  output logic [3:0]  pending_cnt,
  output logic        ref_overflow,
`ifdef REF_STATS_EN
  output logic [15:0] ref_count,
`endif
  output logic [1:0]  dbg_state_o
);

  // Handshake: ref_req is a level; ref_ack is a one-cycle pulse that is accepted
  // only in a cycle where ref_req is high (and init_done is high), ignored otherwise.

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_COUNT    = 2'd1,
    ST_RFC      = 2'd2
  } state_t;

  localparam logic [15:0] TREFI_LAST = 16'(TREFI_CYC - 1);
  localparam logic [7:0]  RFC_LOAD   = 8'(TRFC_CYC - 1);
  localparam logic [3:0]  PEND_SAT   = 4'(MAX_POSTPONE + 1);
  localparam logic [3:0]  PEND_URG   = 4'(MAX_POSTPONE);

  state_t      state_q, state_d;
  logic [15:0] intv_q, intv_d;
  logic [7:0]  rfc_q, rfc_d;
  logic [3:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        tick;
  logic        ack_acc;

  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) begin
      state_q <= ST_DISABLED;
      intv_q  <= '0;
      rfc_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      intv_q  <= intv_d;
      rfc_q   <= rfc_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    intv_d  = intv_q;
    rfc_d   = rfc_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    tick    = (intv_q == TREFI_LAST);
    ack_acc = init_done && ref_ack && ref_req;

    if (!init_done) begin
      // Overflow is sticky across disable; only reset clears it.
      state_d = ST_DISABLED;
      intv_d  = '0;
      rfc_d   = '0;
      pend_d  = '0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_COUNT;
        end
        ST_COUNT, ST_RFC: begin
          intv_d = tick ? 16'd0 : intv_q + 16'd1;
          // A tick and an accepted ack in the same cycle cancel out.
          if (tick && !ack_acc) begin
            if (pend_q == PEND_SAT) ovf_d = 1'b1;
            else                    pend_d = pend_q + 4'd1;
          end else if (ack_acc && !tick) begin
            pend_d = pend_q - 4'd1;
          end

          if (state_q == ST_COUNT) begin
            if (ack_acc) begin
              state_d = ST_RFC;
              rfc_d   = RFC_LOAD;
            end
          end else if (rfc_q == 8'd0) begin
            state_d = ST_COUNT;
          end else begin
            rfc_d = rfc_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_DISABLED;
        end
      endcase
    end
  end

  assign ref_req      = (state_q == ST_COUNT) && (pend_q != 4'd0);
  assign ref_busy     = (state_q == ST_RFC);
  assign ref_urgent   = (pend_q >= PEND_URG);
  assign pending_cnt  = pend_q;
  assign ref_overflow = ovf_q;
  assign dbg_state_o  = state_q;

`ifdef REF_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ack_acc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign ref_count = cnt_q;
`endif

endmodule

// File: tb/tb_ddr4_refresh_scheduler.sv
// Scoreboard bench for ddr4_refresh_scheduler: a cycle-level reference model pushes the
// expected post-edge outputs into exp_q; a monitor pops and compares after each edge.
module tb_ddr4_refresh_scheduler;

  localparam int TREFI = 10;
  localparam int TRFC  = 3;
  localparam int MAXP  = 8;
  localparam int W     = 24;

  logic        clk_50mhz = 1'b0;
  logic        rst_50mhz;
  logic        init_done;
  logic        ref_ack;
  logic        ref_req;
  logic        ref_urgent;
  logic        ref_busy;
  logic [3:0]  pending_cnt;
  logic        ref_overflow;
  logic [1:0]  dbg_state;
`ifdef REF_STATS_EN
  logic [15:0] ref_count;
`endif

  ddr4_refresh_scheduler #(
    .TREFI_CYC    (TREFI),
    .TRFC_CYC     (TRFC),
    .MAX_POSTPONE (MAXP)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .rst_50mhz    (rst_50mhz),
    .init_done    (init_done),
    .ref_ack      (ref_ack),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .ref_busy     (ref_busy),
    .pending_cnt  (pending_cnt),
    .ref_overflow (ref_overflow),
`ifdef REF_STATS_EN
    .ref_count    (ref_count),
`endif
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_50mhz = ~clk_50mhz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc_no, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Enabled flag, enabled-cycle count (ticks on every TREFI-th), remaining busy cycles,
  // owed refreshes, sticky overflow and accepted-refresh total.
  bit m_en   = 0;
  int m_cyc  = 0;
  int m_busy = 0;
  int m_pend = 0;
  bit m_ovf  = 0;
  int m_cnt  = 0;

  function automatic logic [W-1:0] model_outputs();
    logic        req, urg, busy;
    logic [3:0]  pend;
    logic [15:0] cnt;
    req  = m_en && (m_busy == 0) && (m_pend > 0);
    urg  = (m_pend >= MAXP);
    busy = (m_busy > 0);
    pend = 4'(m_pend);
    cnt  = 16'(m_cnt);
    return {req, urg, busy, pend, m_ovf, cnt};
  endfunction

  task automatic model_step(input logic init, input logic ack);
    bit tick, req, acc;
    int newp;
    if (!init) begin
      m_en = 0; m_cyc = 0; m_busy = 0; m_pend = 0;
    end else if (!m_en) begin
      m_en = 1; m_cyc = 0;
    end else begin
      tick = ((m_cyc % TREFI) == TREFI - 1);
      m_cyc++;
      req  = (m_busy == 0) && (m_pend > 0);
      acc  = ack && req;
      newp = m_pend + int'(tick) - int'(acc);
      if (newp > MAXP + 1) begin
        newp  = MAXP + 1;
        m_ovf = 1;
      end
      m_pend = newp;
      if (acc)             m_busy = TRFC;
      else if (m_busy > 0) m_busy--;
      if (acc && m_cnt < 65535) m_cnt++;
    end
    exp_q.push_back(model_outputs());
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic init, input logic ack);
    @(negedge clk_50mhz);
    init_done = init;
    ref_ack   = ack;
    model_step(init, ack);
    @(posedge clk_50mhz);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk_50mhz);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ref_req",      int'(ref_req),      int'(e[23]));
        chk("ref_urgent",   int'(ref_urgent),   int'(e[22]));
        chk("ref_busy",     int'(ref_busy),     int'(e[21]));
        chk("pending_cnt",  int'(pending_cnt),  int'(e[20:17]));
        chk("ref_overflow", int'(ref_overflow), int'(e[16]));
`ifdef REF_STATS_EN
        chk("ref_count",    int'(ref_count),    int'(e[15:0]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst_50mhz = 1'b1;
    init_done = 1'b0;
    ref_ack   = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    #1;
    chk("reset_outputs", int'({ref_req, ref_urgent, ref_busy, pending_cnt, ref_overflow}), 0);
`ifdef REF_STATS_EN
    chk("reset_ref_count", int'(ref_count), 0);
`endif
    @(negedge clk_50mhz);
    rst_50mhz = 1'b0;

    // Held disabled: nothing may be requested.
    repeat (50) step(1'b0, 1'b0);

    // Enabled with no acks: pending climbs to MAX+1, then overflow.
    repeat (105) step(1'b1, 1'b0);

    // Accept one refresh, then a stray ack during busy.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);

    // Drop init_done mid-refresh.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Re-enable and ack exactly on a tick cycle with two refreshes owed.
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_en && m_pend == 2 && m_busy == 0 && (m_cyc % TREFI) == TREFI - 1) begin
        found = 1;
        break;
      end
      step(1'b1, 1'b0);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_ack_setup cycle=%0d actual=not_reached required=pending2_on_tick", cyc_no);
    end else begin
      step(1'b1, 1'b1);
    end
    repeat (8) step(1'b1, 1'b0);

    // Randomized traffic with occasional disables.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0));
    end

    @(negedge clk_50mhz);
    ref_ack = 1'b0;
    repeat (2) @(posedge clk_50mhz);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
